sram_fifo_ctrl: RTL and testbench



---
 rtl/sram_fifo_ctrl_pkg.sv | 16 +
 rtl/sram_fifo_ctrl_if.sv | 32 +++
 rtl/sram_fifo_ctrl_obuf.sv | 54 +++++
 rtl/sram_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants and access-select encoding for the SRAM-backed byte FIFO.
// Widths are tied to the single-port 256x8 macro this controller drives.
package sram_fifo_pkg;

  localparam int DW       = 8;
  localparam int AW       = 8;
  localparam int DEPTH    = 1 << AW;
  localparam int OB_DEPTH = 2;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WR,
    ACC_RD
  } acc_e;

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Producer/consumer streams plus macro pins of the SRAM FIFO controller.
// The controller takes the slave view; bench and wrapper take the master view.
interface sram_fifo_ctrl_if;
  import sram_fifo_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic [AW-1:0] sram_A;
  logic [DW-1:0] sram_I;
  logic [DW-1:0] sram_O;
  logic          sram_CSB;
  logic          sram_WEB;
  logic          sram_OEB;

  modport slave (
    input  in_valid, in_data, out_ready, sram_O,
    output in_ready, out_valid, out_data, count,
           sram_A, sram_I, sram_CSB, sram_WEB, sram_OEB
  );

  modport master (
    output in_valid, in_data, out_ready, sram_O,
    input  in_ready, out_valid, out_data, count,
           sram_A, sram_I, sram_CSB, sram_WEB, sram_OEB
  );

endinterface

// File: rtl/sram_fifo_ctrl_obuf.sv
// Two-entry output buffer fed by macro read returns and drained by the consumer.
// The controller reserves a slot before every read, so an append never overflows.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic          CE,
  input  logic          RSTB,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);

  logic [DW-1:0] r_ob0;
  logic [DW-1:0] r_ob1;
  logic [1:0]    r_cnt;
  logic          w_pop;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign o_data = r_ob0;
  assign o_cnt  = r_cnt;

  always_ff @(posedge CE) begin
    if (!RSTB) begin
      r_ob0 <= '0;
      r_ob1 <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ob0 <= i_push_data;
          else               r_ob1 <= i_push_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ob0 <= r_ob1;
          r_cnt <= r_cnt - 2'd1;
        end
        // Simultaneous pop and append: the new byte lands behind whatever remains.
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_ob0 <= i_push_data;
          end else begin
            r_ob0 <= r_ob1;
            r_ob1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Byte FIFO built on one single-port SRAM macro: arbitrates one access per cycle
// between producer writes and refill reads into a two-entry output buffer.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic             CE,
  input  logic             RSTB,
  sram_fifo_ctrl_if.slave  bus
);

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_M = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_last_a;
  logic [DW-1:0] r_last_i;
  logic [AW:0]   r_mcount;
  logic          r_rd_pend;

  logic [1:0]    w_ob_cnt;
  logic [1:0]    w_occ;
  logic [DW-1:0] w_ob_head;
  logic          w_rd_urgent;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_pop;
  acc_e          w_acc;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // Writes win unless the output side is starved, in which case a read is forced.
  always_comb begin
    w_occ       = w_ob_cnt + {1'b0, r_rd_pend};
    w_rd_urgent = (r_mcount != '0) && (w_occ == 2'd0);
    w_in_ready  = RSTB && (r_mcount < FULL) && !w_rd_urgent;
    w_out_valid = RSTB && (w_ob_cnt != 2'd0);
    w_pop       = w_out_valid && bus.out_ready;
    w_acc       = ACC_IDLE;
    if (bus.in_valid && w_in_ready)
      w_acc = ACC_WR;
    else if (RSTB && (r_mcount != '0) && (w_occ < 2'd2))
      w_acc = ACC_RD;
  end

  always_comb begin
    w_addr  = r_last_a;
    w_wdata = r_last_i;
    if (!RSTB) begin
      w_addr  = '0;
      w_wdata = '0;
    end else if (w_acc == ACC_WR) begin
      w_addr  = r_wptr;
      w_wdata = bus.in_data;
    end else if (w_acc == ACC_RD) begin
      w_addr  = r_rptr;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_ob_head;
  assign bus.count     = RSTB ? r_mcount : '0;
  assign bus.sram_A    = w_addr;
  assign bus.sram_I    = w_wdata;
  assign bus.sram_CSB  = (w_acc == ACC_IDLE);
  assign bus.sram_WEB  = (w_acc != ACC_WR);
  assign bus.sram_OEB  = (w_acc != ACC_RD);

  always_ff @(posedge CE) begin
    if (!RSTB) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_last_a  <= '0;
      r_last_i  <= '0;
      r_mcount  <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= (w_acc == ACC_RD);
      case (w_acc)
        ACC_WR: begin
          r_wptr   <= r_wptr + ONE_P;
          r_mcount <= r_mcount + ONE_M;
          r_last_a <= r_wptr;
          r_last_i <= bus.in_data;
        end
        ACC_RD: begin
          r_rptr   <= r_rptr + ONE_P;
          r_mcount <= r_mcount - ONE_M;
          r_last_a <= r_rptr;
        end
        default: ;
      endcase
    end
  end

  // The macro's registered read data is valid exactly one cycle after the RD strobe.
  sram_fifo_obuf u_obuf (
    .CE          (CE),
    .RSTB        (RSTB),
    .i_push      (r_rd_pend),
    .i_push_data (bus.sram_O),
    .i_pop       (w_pop),
    .o_data      (w_ob_head),
    .o_cnt       (w_ob_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 256x8 registered-output macro.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  logic CE;
  logic RSTB;
  sram_fifo_ctrl_if bus ();

  sram_fifo_ctrl dut (
    .CE   (CE),
    .RSTB (RSTB),
    .bus  (bus)
  );

  logic [7:0] macroMem [256];
  bit         bothLowSeen = 1'b0;
  int         vectors     = 0;
  int         miscompares = 0;

  initial CE = 1'b0;
  always #5 CE = ~CE;

  always @(posedge CE) begin
    if (!bus.sram_CSB && !bus.sram_WEB) macroMem[bus.sram_A] <= bus.sram_I;
    if (!bus.sram_CSB && !bus.sram_OEB) bus.sram_O <= macroMem[bus.sram_A];
  end

  always @(negedge CE) begin
    if (!bus.sram_WEB && !bus.sram_OEB) bothLowSeen = 1'b1;
  end

  task automatic nextCycle();
    @(posedge CE);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.out_ready = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before the sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   accepted;
    int   drained;
    int   pushed;
    int   popped;
    int   orderErrors;
    int   accessCycles;
    bit   found;
    logic rdy;

    RSTB = 1'b0;
    applyStimulus(1'b1, 8'h5A, 1'b0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 8'h5A, 1'b0);
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstCount", 32'(bus.count), 32'd0);
    checkOutput("rstStrobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h7);
    checkOutput("rstAddr", 32'(bus.sram_A), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    RSTB = 1'b1;
    nextCycle();
    checkOutput("idleInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("idleStrobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h7);

    // Single byte through an empty FIFO: WR, RD, return, visible at t+3
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("c0Strobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h1);
    checkOutput("c0Addr", 32'(bus.sram_A), 32'h00);
    checkOutput("c0WData", 32'(bus.sram_I), 32'hA5);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("c1Strobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h2);
    checkOutput("c1Count", 32'(bus.count), 32'd1);
    checkOutput("c1InReady", 32'(bus.in_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("c2Strobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h7);
    checkOutput("c2HoldWData", 32'(bus.sram_I), 32'hA5);
    checkOutput("c2OutValid", 32'(bus.out_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("c3OutValid", 32'(bus.out_valid), 32'd1);
    checkOutput("c3OutData", 32'(bus.out_data), 32'hA5);
    checkOutput("c3Count", 32'(bus.count), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("c4OutValid", 32'(bus.out_valid), 32'd0);

    // Fill: 256 macro entries plus two buffered bytes
    accepted = 0;
    for (int c = 0; c < 400 && accepted < 258; c++) begin
      applyStimulus(1'b1, 8'(accepted), 1'b0);
      if (bus.in_ready) accepted++;
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fillAccepted", accepted, 32'd258);
    checkOutput("fullInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("fullCount", 32'(bus.count), 32'd256);
    checkOutput("fullOutValid", 32'(bus.out_valid), 32'd1);
    checkOutput("fullHead", 32'(bus.out_data), 32'h00);
    checkOutput("fullStrobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h7);

    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("popOneHead", 32'(bus.out_data), 32'h00);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("popOneInReady", 32'(bus.in_ready), 32'd0);
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 8'h02, 1'b0);
      if (bus.in_ready) accepted++;
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("refillAccepts", accepted, 32'd1);
    checkOutput("refillCount", 32'(bus.count), 32'd256);

    drained = 0;
    orderErrors = 0;
    for (int c = 0; c < 1200 && drained < 258; c++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (bus.out_valid) begin
        if (bus.out_data !== 8'(drained + 1)) orderErrors++;
        drained++;
      end
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("drainCount", drained, 32'd258);
    checkOutput("drainOrder", orderErrors, 32'd0);
    checkOutput("drainEmptyCount", 32'(bus.count), 32'd0);
    checkOutput("drainOutValid", 32'(bus.out_valid), 32'd0);

    // 1 + 259 writes so far leave both pointers at 4 after wrapping
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("wrapInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("wrapAddr", 32'(bus.sram_A), 32'd4);
    checkOutput("wrapStrobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      if (bus.out_valid) begin
        found = 1'b1;
        checkOutput("wrapData", 32'(bus.out_data), 32'h77);
      end else begin
        nextCycle();
      end
    end
    checkOutput("wrapFound", 32'(found), 32'd1);
    nextCycle();

    pushed = 0;
    popped = 0;
    orderErrors = 0;
    accessCycles = 0;
    for (int c = 0; c < 1000; c++) begin
      applyStimulus(1'b1, 8'(pushed), 1'b1);
      if (!bus.sram_CSB) accessCycles++;
      if (bus.in_ready) pushed++;
      if (bus.out_valid) begin
        if (bus.out_data !== 8'(popped)) orderErrors++;
        popped++;
      end
      nextCycle();
    end
    for (int c = 0; c < 1000 && popped < pushed; c++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (bus.out_valid) begin
        if (bus.out_data !== 8'(popped)) orderErrors++;
        popped++;
      end
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("streamOrder", orderErrors, 32'd0);
    checkOutput("streamBalance", popped, pushed);
    checkOutput("streamAccessEveryCycle", 32'(accessCycles >= 990), 32'd1);
    checkOutput("streamHalfRate", 32'(pushed >= 500), 32'd1);
    checkOutput("streamEmptyCount", 32'(bus.count), 32'd0);

    accepted = 0;
    for (int c = 0; c < 20 && accepted < 3; c++) begin
      applyStimulus(1'b1, 8'hB0 + 8'(accepted), 1'b0);
      if (bus.in_ready) accepted++;
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stallAccepted", accepted, 32'd3);
    popped = 0;
    orderErrors = 0;
    for (int c = 0; c < 100 && popped < 3; c++) begin
      rdy = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 8'h00, rdy);
      if (bus.out_valid && rdy) begin
        if (bus.out_data !== 8'hB0 + 8'(popped)) orderErrors++;
        popped++;
      end
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("stallPopped", popped, 32'd3);
    checkOutput("stallOrder", orderErrors, 32'd0);
    checkOutput("stallNoExtra", 32'(bus.out_valid), 32'd0);

    // Reset with one byte buffered and a read in flight
    accepted = 0;
    for (int c = 0; c < 20 && accepted < 5; c++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(accepted), 1'b0);
      if (bus.in_ready) accepted++;
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("preRstStrobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h2);
    nextCycle();
    checkOutput("preRstOutValid", 32'(bus.out_valid), 32'd1);
    checkOutput("preRstCount", 32'(bus.count), 32'd3);
    RSTB = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("midRstCount", 32'(bus.count), 32'd0);
    checkOutput("midRstStrobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h7);
    checkOutput("midRstAddr", 32'(bus.sram_A), 32'd0);
    checkOutput("midRstWData", 32'(bus.sram_I), 32'd0);
    nextCycle();
    checkOutput("postRstEdgeOutValid", 32'(bus.out_valid), 32'd0);
    RSTB = 1'b1;
    nextCycle();
    checkOutput("discardOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("discardCount", 32'(bus.count), 32'd0);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("postRstAddr", 32'(bus.sram_A), 32'd0);
    checkOutput("postRstStrobes", 32'({bus.sram_CSB, bus.sram_WEB, bus.sram_OEB}), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("postRstOutValid", 32'(bus.out_valid), 32'd1);
    checkOutput("postRstData", 32'(bus.out_data), 32'h3C);
    nextCycle();

    checkOutput("webOebExclusive", 32'(bothLowSeen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
